bit_serializer: RTL and testbench



---
 rtl/bit_serializer.sv | 160 ++++++++++++++++
 tb/tb_bit_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial stimulus stage: shifts a WIDTH-bit pattern out one bit per
// DIV-cycle bit period, MSB- or LSB-first, framed by a ready/done handshake.
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         din,
    input  logic                     msb_first,
    output logic                     ready,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     done
);

    localparam int IW = $clog2(WIDTH);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit that leaves the shift register first for the given direction.
    function automatic logic head_bit(input logic [WIDTH-1:0] v, input logic msb);
        logic b;
        if (msb) begin
            b = v[WIDTH-1];
        end else begin
            b = v[0];
        end
        return b;
    endfunction

    // Shift register after one bit has been consumed.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v, input logic msb);
        logic [WIDTH-1:0] r;
        if (msb) begin
            r = {v[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_msb;
    logic [PW-1:0]    r_pre;
    logic [IW-1:0]    r_bit_idx;
    logic             r_ready;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_msb_nxt;
    logic [PW-1:0]    w_pre_nxt;
    logic [IW-1:0]    w_idx_nxt;
    logic             w_ready_nxt;
    logic             w_bit_nxt;
    logic             w_valid_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_shift_adv;

    assign w_shift_adv = advance(r_shift, r_msb);

    // Next-state and next-output logic; outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_msb_nxt   = r_msb;
        w_pre_nxt   = r_pre;
        w_idx_nxt   = {IW{1'b0}};
        w_ready_nxt = 1'b0;
        w_bit_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nxt = S_SHIFT;
                    w_shift_nxt = din;
                    w_msb_nxt   = msb_first;
                    w_pre_nxt   = {PW{1'b0}};
                    w_bit_nxt   = head_bit(din, msb_first);
                    w_valid_nxt = 1'b1;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_pre == PRE_MAX) begin
                    w_pre_nxt = {PW{1'b0}};
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_shift_nxt = w_shift_adv;
                        w_idx_nxt   = r_bit_idx + IW'(1);
                        w_bit_nxt   = head_bit(w_shift_adv, r_msb);
                        w_valid_nxt = 1'b1;
                    end
                end else begin
                    // Hold the current bit for the rest of its prescaled period.
                    w_pre_nxt = r_pre + PW'(1);
                    w_idx_nxt = r_bit_idx;
                    w_bit_nxt = head_bit(r_shift, r_msb);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= {WIDTH{1'b0}};
            r_msb       <= 1'b0;
            r_pre       <= {PW{1'b0}};
            r_bit_idx   <= {IW{1'b0}};
            r_ready     <= 1'b1;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_msb       <= w_msb_nxt;
            r_pre       <= w_pre_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_ready     <= w_ready_nxt;
            r_bit_out   <= w_bit_nxt;
            r_bit_valid <= w_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign ready     = r_ready;
    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign bit_idx   = r_bit_idx;
    assign done      = r_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one instance with DIV=1, one with DIV=3.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load1, msb1, load3, msb3;
    logic [7:0] din1, din3;
    logic       ready1, bit1, valid1, done1;
    logic       ready3, bit3, valid3, done3;
    logic [2:0] idx1, idx3;

    int nvec  = 0;
    int nfail = 0;

    logic [7:0] seq;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .load(load1), .din(din1), .msb_first(msb1),
        .ready(ready1), .bit_out(bit1), .bit_valid(valid1), .bit_idx(idx1), .done(done1)
    );

    bit_serializer #(.WIDTH(8), .DIV(3)) u_d3 (
        .clk(clk), .reset(reset), .load(load3), .din(din3), .msb_first(msb3),
        .ready(ready3), .bit_out(bit3), .bit_valid(valid3), .bit_idx(idx3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Full output vector of the DIV=1 instance.
    task automatic chk1(input string tag, input logic r, input logic b, input logic v,
                        input logic [2:0] i, input logic d);
        chk({tag, ".ready"}, {31'd0, ready1}, {31'd0, r});
        chk({tag, ".bit_out"}, {31'd0, bit1}, {31'd0, b});
        chk({tag, ".bit_valid"}, {31'd0, valid1}, {31'd0, v});
        chk({tag, ".bit_idx"}, {29'd0, idx1}, {29'd0, i});
        chk({tag, ".done"}, {31'd0, done1}, {31'd0, d});
    endtask

    initial begin
        reset = 1'b1;
        load1 = 1'b0; msb1 = 1'b0; din1 = 8'h00;
        load3 = 1'b0; msb3 = 1'b0; din3 = 8'h00;

        // 1: reset for two cycles
        tick(); tick();
        reset = 1'b0;
        chk1("rst", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("rst.ready3", {31'd0, ready3}, 32'd1);
        chk("rst.done3", {31'd0, done3}, 32'd0);

        // 2: F0 MSB-first
        din1 = 8'hF0; msb1 = 1'b1; load1 = 1'b1;
        seq = 8'b1111_0000;
        for (int k = 0; k < 8; k++) begin
            tick();
            load1 = 1'b0;
            chk1("t2.bit", 1'b0, seq[7-k], 1'b1, 3'(k), 1'b0);
        end
        tick();
        chk1("t2.done", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        chk1("t2.ready", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        // 3: 07 LSB-first, din disturbed after acceptance
        din1 = 8'b0000_0111; msb1 = 1'b0; load1 = 1'b1;
        seq = 8'b1110_0000;
        for (int k = 0; k < 8; k++) begin
            tick();
            load1 = 1'b0;
            chk1("t3.bit", 1'b0, seq[7-k], 1'b1, 3'(k), 1'b0);
            if (k == 1) begin
                din1 = 8'hFF;
                msb1 = 1'b1;
            end
        end
        tick();
        chk1("t3.done", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        chk1("t3.ready", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        // 4: DIV=3, A5 MSB-first
        din3 = 8'hA5; msb3 = 1'b1; load3 = 1'b1;
        chk("t4.ready0", {31'd0, ready3}, 32'd1);
        seq = 8'b1010_0101;
        for (int c = 0; c < 24; c++) begin
            tick();
            load3 = 1'b0;
            chk("t4.bit_out", {31'd0, bit3}, {31'd0, seq[7-c/3]});
            chk("t4.bit_valid", {31'd0, valid3}, (c % 3 == 0) ? 32'd1 : 32'd0);
            chk("t4.bit_idx", {29'd0, idx3}, 32'(c / 3));
            chk("t4.done", {31'd0, done3}, 32'd0);
            chk("t4.ready", {31'd0, ready3}, 32'd0);
        end
        tick();
        chk("t4.done_pulse", {31'd0, done3}, 32'd1);
        chk("t4.done_bit", {31'd0, bit3}, 32'd0);
        tick();
        chk("t4.ready_back", {31'd0, ready3}, 32'd1);
        chk("t4.done_low", {31'd0, done3}, 32'd0);

        // 5a: load during SHIFT is ignored
        din1 = 8'hC3; msb1 = 1'b1; load1 = 1'b1;
        seq = 8'b1100_0011;
        for (int k = 0; k < 8; k++) begin
            tick();
            load1 = (k == 2) ? 1'b1 : 1'b0;
            if (k == 2) begin
                din1 = 8'h00;
                msb1 = 1'b0;
            end
            chk1("t5.bit", 1'b0, seq[7-k], 1'b1, 3'(k), 1'b0);
        end
        load1 = 1'b0;
        tick();
        chk1("t5.done", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        chk1("t5.ready", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        // 5b: reset mid-frame at bit_idx 3
        din1 = 8'hFF; msb1 = 1'b1; load1 = 1'b1;
        tick(); load1 = 1'b0;
        tick(); tick(); tick();
        chk1("t5b.pre", 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("t5b.abort", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            tick();
            chk1("t5b.no_done", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        end

        // reset together with load: load not accepted
        reset = 1'b1; load1 = 1'b1; din1 = 8'hFF;
        tick();
        reset = 1'b0; load1 = 1'b0;
        chk1("rl.idle", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        chk1("rl.still", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        // 6: load held high for 30 cycles
        din1 = 8'h5A; msb1 = 1'b1; load1 = 1'b1;
        seq = 8'b0101_1010;
        for (int c = 0; c < 30; c++) begin
            chk("t6.ready", {31'd0, ready1}, (c % 10 == 0) ? 32'd1 : 32'd0);
            chk("t6.done", {31'd0, done1}, (c % 10 == 9) ? 32'd1 : 32'd0);
            if ((c % 10 >= 1) && (c % 10 <= 8)) begin
                chk("t6.bit_out", {31'd0, bit1}, {31'd0, seq[8-(c%10)]});
                chk("t6.bit_idx", {29'd0, idx1}, 32'((c % 10) - 1));
            end
            tick();
        end
        load1 = 1'b0;
        chk1("t6.end", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        chk1("t6.idle", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
